// File: rtl/vec_lane_exec.sv
// vec_lane_exec: multi-cycle predicated vector ALU, PAR lanes per beat; request (op,src_a,src_b,imm,use_imm,mask) via in_valid/in_ready, response (result, NZCV flags) via out_valid/out_ready, busy while working
module vec_lane_exec #(
  parameter int WIDTH = 32,
  parameter int LANES = 16,
  parameter int PAR = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             op,
  input  logic [LANES*WIDTH-1:0] src_a,
  input  logic [LANES*WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0]       imm,
  input  logic                   use_imm,
  input  logic [LANES-1:0]       mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result,
  output logic [3:0]             flags,
  output logic                   busy
);
  localparam int BEATS = LANES / PAR;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int SW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t                 state_q;
  logic [3:0]             op_q;
  logic [LANES*WIDTH-1:0] a_q, b_q, result_q, result_d;
  logic [LANES-1:0]       mask_q;
  logic [BW-1:0]          beat_q;
  logic [WIDTH-1:0]       sum_q, sum_d, la, lb, lbb, lr;
  logic [WIDTH:0]         lext, rs;
  logic                   n_q, z_q, c_q, v_q, n_d, z_d, c_d, v_d;
  logic [3:0]             flags_q, flags_d;
  logic                   red, arith, is_sub, last;
  int                     l;
  assign red = op_q == 4'd7;
  assign is_sub = op_q == 4'd1;
  assign arith = op_q == 4'd0 || is_sub || op_q[3];
  assign last = beat_q == BW'(BEATS - 1);
  always_comb begin
    result_d = result_q;
    sum_d = sum_q;
    n_d = n_q;
    z_d = z_q;
    c_d = c_q;
    v_d = v_q;
    l = 0;
    la = '0;
    lb = '0;
    lbb = '0;
    lext = '0;
    lr = '0;
    rs = '0;
    for (int j = 0; j < PAR; j++) begin
      l = int'(beat_q) * PAR + j;
      la = a_q[l*WIDTH +: WIDTH];
      lb = b_q[l*WIDTH +: WIDTH];
      lbb = is_sub ? ~lb : lb;
      lext = {1'b0, la} + {1'b0, lbb} + {{WIDTH{1'b0}}, is_sub};
      lr = op_q == 4'd2 ? la & lb :
           op_q == 4'd3 ? la | lb :
           op_q == 4'd4 ? la ^ lb :
           op_q == 4'd5 ? la << lb[SW-1:0] :
           op_q == 4'd6 ? la >> lb[SW-1:0] : lext[WIDTH-1:0];
      rs = {1'b0, sum_d} + {1'b0, la};
      result_d[l*WIDTH +: WIDTH] = mask_q[l] && !red ? lr : la;
      if (mask_q[l] && red) begin
        sum_d = rs[WIDTH-1:0];
        c_d = c_d | rs[WIDTH];
      end
      if (mask_q[l] && !red) begin
        n_d = n_d | lr[WIDTH-1];
        z_d = z_d & (lr == '0);
        c_d = c_d | (arith & lext[WIDTH]);
        v_d = v_d | (arith & (la[WIDTH-1] == lbb[WIDTH-1]) & (lr[WIDTH-1] != la[WIDTH-1]));
      end
    end
    if (red && last) result_d[WIDTH-1:0] = |mask_q ? sum_d : a_q[WIDTH-1:0];
    flags_d = red ? {sum_d[WIDTH-1], sum_d == '0, c_d, 1'b0} : {n_d, z_d, c_d, v_d};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      mask_q <= '0;
      beat_q <= '0;
      sum_q <= '0;
      n_q <= 1'b0;
      z_q <= 1'b0;
      c_q <= 1'b0;
      v_q <= 1'b0;
      result_q <= '0;
      flags_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_q <= op;
          a_q <= src_a;
          b_q <= use_imm ? {LANES{imm}} : src_b;
          mask_q <= mask;
          beat_q <= '0;
          sum_q <= '0;
          n_q <= 1'b0;
          z_q <= 1'b1;
          c_q <= 1'b0;
          v_q <= 1'b0;
          state_q <= EXEC;
        end
        EXEC: begin
          result_q <= result_d;
          flags_q <= flags_d;
          sum_q <= sum_d;
          n_q <= n_d;
          z_q <= z_d;
          c_q <= c_d;
          v_q <= v_d;
          beat_q <= beat_q + 1'b1;
          state_q <= last ? DONE : EXEC;
        end
        DONE: state_q <= out_ready ? IDLE : DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign result = result_q;
  assign flags = flags_q;
endmodule

// File: tb/tb_vec_lane_exec.sv
// tb_vec_lane_exec: scoreboard bench for vec_lane_exec with a lane-by-lane arithmetic reference model
module tb_vec_lane_exec;
  localparam int W = 32;
  localparam int L = 16;
  localparam int P = 4;
  localparam int B = L / P;
  localparam int SW = $clog2(W);
  typedef logic [L*W-1:0] vec_t;
  typedef struct {
    vec_t res;
    logic [3:0] fl;
    int acc;
    bit seen;
  } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, use_imm = 0, out_valid, out_ready = 0, busy;
  logic [3:0] op = 0, flags;
  vec_t src_a = '0, src_b = '0, result;
  logic [W-1:0] imm = '0;
  logic [L-1:0] mask = '0;
  exp_t sb[$];
  int passed = 0, total = 0, cyc = 0, hs_cyc = -10;
  bit hold_low = 0;
  vec_t a, b;
  vec_t ones;
  vec_t zero_v;
  vec_t mask_v;
  vec_t full;
  vec_t dummy;
  vec_t cnt_v;
  vec_t bb;
  vec_t aa;
  vec_t rv;
  vec_t tmp;
  vec_t tmp2;
  vec_t tmp3;
  vec_t tmp4;
  logic [L-1:0] m;
  vec_lane_exec #(.WIDTH(W), .LANES(L), .PAR(P)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src_a(src_a), .src_b(src_b), .imm(imm), .use_imm(use_imm), .mask(mask),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input vec_t act, input vec_t exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask
  function automatic exp_t model(input logic [3:0] o, input vec_t va, input vec_t vb, input logic [L-1:0] mk);
    exp_t e;
    logic [W-1:0] x, y, r, sum;
    logic [W:0] t;
    logic n, z, c, v, cc, vv;
    e.res = va;
    e.acc = 0;
    e.seen = 0;
    n = 0; z = 1; c = 0; v = 0; sum = '0;
    for (int i = 0; i < L; i++) begin
      x = va[i*W +: W];
      y = vb[i*W +: W];
      if (!mk[i]) continue;
      if (o == 4'd7) begin
        t = {1'b0, sum} + {1'b0, x};
        c = c | t[W];
        sum = t[W-1:0];
        continue;
      end
      cc = 0; vv = 0;
      case (o)
        4'd1: begin
          r = x - y;
          cc = x >= y;
          vv = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        end
        4'd2: r = x & y;
        4'd3: r = x | y;
        4'd4: r = x ^ y;
        4'd5: r = x << y[SW-1:0];
        4'd6: r = x >> y[SW-1:0];
        default: begin
          r = x + y;
          cc = r < x;
          vv = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        end
      endcase
      e.res[i*W +: W] = r;
      n = n | r[W-1];
      z = z & (r == 0);
      c = c | cc;
      v = v | vv;
    end
    if (o == 4'd7) begin
      if (mk != 0) e.res[W-1:0] = sum;
      e.fl = {sum[W-1], sum == 0, c, 1'b0};
    end else e.fl = {n, z, c, v};
    return e;
  endfunction
  task automatic send(input logic [3:0] o, input vec_t va, input vec_t vb, input logic [W-1:0] im, input logic ui, input logic [L-1:0] mk);
    exp_t e;
    bit held;
    int k;
    op = o; src_a = va; src_b = vb; imm = im; use_imm = ui; mask = mk;
    in_valid = 1;
    held = !in_ready;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 100);
    if (!in_ready) begin
      total++;
      $display("FAIL accept_timeout: in_ready stayed %b after %0d cycles, want 1", in_ready, k);
      in_valid = 0;
      return;
    end
    e = model(o, va, ui ? {L{im}} : vb, mk);
    e.acc = cyc + 1;
    sb.push_back(e);
    if (held) chk("accept_after_handshake", vec_t'(e.acc), vec_t'(hs_cyc + 1));
    @(posedge clk);
    #1;
    in_valid = 0;
    op = $urandom; src_a = {L{$urandom()}}; src_b = {L{$urandom()}}; mask = $urandom;
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_out_valid: out_valid=%b with empty scoreboard, want 0", out_valid);
        end else begin
          chk("result", result, sb[0].res);
          chk("flags", vec_t'(flags), vec_t'(sb[0].fl));
          chk("in_ready_in_done", vec_t'(in_ready), vec_t'(0));
          if (!sb[0].seen) begin
            chk("latency", vec_t'(cyc - sb[0].acc), vec_t'(B));
            sb[0].seen = 1;
          end
          if (out_ready) begin
            hs_cyc = cyc + 1;
            void'(sb.pop_front());
          end
        end
      end
    end
  end
  initial begin
    #23;
    chk("reset_in_ready", vec_t'(in_ready), vec_t'(1));
    chk("reset_out_valid", vec_t'(out_valid), vec_t'(0));
    chk("reset_busy", vec_t'(busy), vec_t'(0));
    chk("reset_result", result, '0);
    chk("reset_flags", vec_t'(flags), '0);
    @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < L; i++) begin
      a[i*W +: W] = i;
      b[i*W +: W] = 100;
    end
    send(4'd0, a, b, '0, 0, '1);
    for (int i = 0; i < L; i++) a[i*W +: W] = i == 0 ? 5 : 7;
    b = {L{32'd5}};
    send(4'd1, a, b, '0, 0, 16'h0001);
    b = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    send(4'd0, {L{32'd1}}, b, 32'hFFFF_FFFF, 1, '1);
    for (int i = 0; i < L; i++) a[i*W +: W] = i + 1;
    send(4'd7, a, b, '0, 0, 16'hF0F0);
    send(4'd7, a, b, '0, 0, 16'h0000);
    send(4'd5, a, b, '0, 0, 16'h0000);
    for (int k = 0; k < 200 && sb.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    #1;
    hold_low = 1;
    send(4'd4, a, b, '0, 0, 16'h5A5A);
    fork
      send(4'd2, b, a, '0, 0, 16'hFFFF);
      begin
        repeat (B + 6) @(posedge clk);
        #1;
        hold_low = 0;
      end
    join
    for (int k = 0; k < 200 && sb.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    #1;
    send(4'd0, a, b, '0, 0, '1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk("abort_in_ready", vec_t'(in_ready), vec_t'(1));
    chk("abort_out_valid", vec_t'(out_valid), vec_t'(0));
    chk("abort_result", result, '0);
    chk("abort_flags", vec_t'(flags), '0);
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    rst = 0;
    send(4'd0, a, a, '0, 0, '1);
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < L; i++) begin
        a[i*W +: W] = $urandom();
        b[i*W +: W] = ($urandom_range(0, 1) != 0) ? $urandom() : $urandom_range(0, 40);
      end
      m = t % 7 == 0 ? '0 : t % 5 == 0 ? '1 : L'($urandom());
      send(4'($urandom_range(0, 15)), a, b, $urandom(), 1'($urandom_range(0, 1)), m);
    end
    for (int k = 0; k < 400 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      total++;
      $display("FAIL drain: %0d results outstanding, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
